// File: rtl/norm_engine.sv
// Normalization responder for the NORM phase: out = sat((in - mean) * inv_var >>> SHIFT), 2-cycle pipeline.
// Define NORM_SATURATE_EN to clamp results to DWIDTH signed range; otherwise results wrap.
module norm_engine #(
   parameter int DWIDTH    = 8,
   parameter int NUM_ELEMS = 16,
   parameter int SHIFT     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_norm,
   input  logic [DWIDTH-1:0] mean,
   input  logic [DWIDTH-1:0] inv_var,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DWIDTH-1:0] out_data,
   output logic              done_norm
);
   localparam int CW = $clog2(NUM_ELEMS + 1);
   localparam int PW = 2*DWIDTH + 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_next;

   logic [CW-1:0]          count;
   logic [DWIDTH-1:0]      mean_q;
   logic [DWIDTH-1:0]      inv_var_q;
   logic signed [DWIDTH:0] diff_q;
   logic                   s1_valid;
   logic                   accept;
   logic                   last_accept;
   logic                   abort;
   logic signed [PW-1:0]   prod;
   logic [DWIDTH-1:0]      result;

   assign accept      = in_valid && in_ready;
   assign abort       = !start_norm && (state == RUN || state == DRAIN);
   assign last_accept = accept && (count == CW'(NUM_ELEMS - 1));

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_norm) state_next = RUN;
         end
         RUN: begin
            if (!start_norm)      state_next = IDLE;
            else if (last_accept) state_next = DRAIN;
         end
         DRAIN: begin
            if (!start_norm)                  state_next = IDLE;
            else if (!s1_valid && !out_valid) state_next = DONE;
         end
         DONE: begin
            if (!start_norm) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // in_ready and done_norm are registered copies of the next state decode
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         done_norm <= 1'b0;
         count     <= '0;
         mean_q    <= '0;
         inv_var_q <= '0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next == RUN);
         done_norm <= (state_next == DONE);
         if (state == IDLE && start_norm) begin
            mean_q    <= mean;
            inv_var_q <= inv_var;
            count     <= '0;
         end else if (accept && start_norm) begin
            count <= count + 1'b1;
         end
      end
   end

   // inv_var is unsigned, so it gets a zero sign bit before the signed multiply
   assign prod = PW'(diff_q) * PW'($signed({1'b0, inv_var_q}));

`ifdef NORM_SATURATE_EN
   localparam logic signed [PW-1:0] SAT_MAX = {{(DWIDTH+3){1'b0}}, {(DWIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(DWIDTH+3){1'b1}}, {(DWIDTH-1){1'b0}}};
   logic signed [PW-1:0] sh;

   assign sh = prod >>> SHIFT;

   always_comb begin
      if (sh > SAT_MAX)      result = SAT_MAX[DWIDTH-1:0];
      else if (sh < SAT_MIN) result = SAT_MIN[DWIDTH-1:0];
      else                   result = sh[DWIDTH-1:0];
   end
`else
   assign result = DWIDTH'(prod >>> SHIFT);
`endif

   // An abort flushes both stages so nothing from the dropped job escapes
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         diff_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         s1_valid <= accept && !abort;
         if (accept)
            diff_q <= $signed({in_data[DWIDTH-1], in_data}) - $signed({mean_q[DWIDTH-1], mean_q});
         out_valid <= s1_valid && !abort;
         if (s1_valid && !abort)
            out_data <= result;
      end
   end

endmodule

// File: tb/tb_norm_engine.sv
// Scoreboard bench for norm_engine (DWIDTH=8, NUM_ELEMS=16, SHIFT=4); expected values are hand-computed.
module tb_norm_engine;
   logic       clk = 1'b0;
   logic       reset;
   logic       start_norm;
   logic [7:0] mean;
   logic [7:0] inv_var;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       done_norm;

   norm_engine #(.DWIDTH(8), .NUM_ELEMS(16), .SHIFT(4)) dut (
      .clk(clk), .reset(reset), .start_norm(start_norm), .mean(mean), .inv_var(inv_var),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .done_norm(done_norm)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_out = 0;
   int n_done_rise = 0;
   logic done_prev = 1'b0;
   int exp_cur = 0;
   int exp_q[$];
   int cyc_q[$];
   int dvec[16];
   int evec[16];

   int ovf_d[8] = '{127, -128, 20, 10, 11, 9, 0, -1};
`ifdef NORM_SATURATE_EN
   int ovf_e[8] = '{127, -128, 20, 0, 2, -2, -20, -22};
`else
   int ovf_e[8] = '{-22, -20, 20, 0, 2, -2, -20, -22};
`endif
   int gap_d[8] = '{-1, 15, 16, -17, 32, -16, 0, 100};
   int gap_e[8] = '{-1, 0, 1, -2, 2, -1, 0, 6};

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor pops first, then the accept observer pushes, so FIFO order is preserved.
   always @(negedge clk) begin
      int e;
      int c;
      if (out_valid) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got %0d expected none", $signed(out_data));
         end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("out_data", int'($signed(out_data)), e);
            chk("latency", cyc - c, 2);
         end
      end
      if (done_norm && !done_prev) n_done_rise++;
      done_prev = done_norm;
      if (in_valid && in_ready && start_norm && !reset) begin
         exp_q.push_back(exp_cur);
         cyc_q.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input int e, output bit ok);
      ok = 1'b0;
      in_data = d[7:0];
      exp_cur = e;
      in_valid = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic begin_job(input int m, input int iv);
      mean = m[7:0];
      inv_var = iv[7:0];
      start_norm = 1'b1;
      n_out = 0;
      n_done_rise = 0;
      @(negedge clk);
      chk("ready_low_start_cycle", in_ready, 0);
      tick();
      mean = 8'h55;   // must have been latched already
      inv_var = 8'h00;
      @(negedge clk);
      chk("ready_after_start", in_ready, 1);
      tick();
   endtask

   task automatic feed(input bit gap);
      bit ok;
      for (int i = 0; i < 16; i++) begin
         send(dvec[i], evec[i], ok);
         chk("accepted", ok, 1);
         if (gap) tick();
      end
   endtask

   task automatic finish_job();
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 60 && !seen; t++) begin
         @(negedge clk);
         if (done_norm) seen = 1'b1;
      end
      chk("done_seen", seen, 1);
      chk("outputs_before_done", n_out, 16);
      chk("sb_empty", exp_q.size(), 0);
      tick();
      start_norm = 1'b0;
      @(negedge clk);
      chk("done_held", done_norm, 1);
      tick();
      @(negedge clk);
      chk("done_cleared", done_norm, 0);
      chk("idle_ready_low", in_ready, 0);
      chk("done_rises", n_done_rise, 1);
      tick();
   endtask

   task automatic fill_const(input int d, input int e);
      for (int i = 0; i < 16; i++) begin
         dvec[i] = d;
         evec[i] = e;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      reset = 1'b1; start_norm = 1'b0; mean = '0; inv_var = '0; in_valid = 1'b0; in_data = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_done", done_norm, 0);
      tick();
      reset = 1'b0;

      // in_valid is ignored while idle
      in_valid = 1'b1; in_data = 8'd50;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_ignores_valid", in_ready, 0);
         tick();
      end
      in_valid = 1'b0;

      // Basic job
      fill_const(20, 20);
      begin_job(10, 32);
      feed(1'b0);
      finish_job();

      // Overflow / wrap behaviour
      for (int i = 0; i < 16; i++) begin
         dvec[i] = ovf_d[i % 8];
         evec[i] = ovf_e[i % 8];
      end
      begin_job(10, 32);
      feed(1'b0);
      finish_job();

      // Gapped input, floor shift, and an overrun sample
      for (int i = 0; i < 16; i++) begin
         dvec[i] = gap_d[i % 8];
         evec[i] = gap_e[i % 8];
      end
      begin_job(0, 1);
      feed(1'b1);
      in_valid = 1'b1; in_data = 8'd5; exp_cur = 999;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("overrun_not_ready", in_ready, 0);
         tick();
      end
      in_valid = 1'b0;
      finish_job();

      // Abort after 5 accepts
      fill_const(20, 20);
      begin_job(10, 32);
      for (int i = 0; i < 5; i++) begin
         send(20, 20, ok);
         chk("abort_accepted", ok, 1);
      end
      start_norm = 1'b0;
      tick();
      @(negedge clk);
      chk("abort_idle_ready", in_ready, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_out", out_valid, 0);
         chk("abort_no_done", done_norm, 0);
         tick();
      end
      chk("abort_outs_le5", int'(n_out <= 5), 1);
      exp_q.delete();
      cyc_q.delete();

      fill_const(-3, -3);
      begin_job(0, 16);
      feed(1'b0);
      finish_job();

      // Reset with the pipeline full
      begin_job(10, 32);
      for (int i = 0; i < 3; i++) begin
         send(20, 20, ok);
         chk("rstjob_accepted", ok, 1);
      end
      reset = 1'b1; start_norm = 1'b0; in_valid = 1'b1;
      tick();
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_done", done_norm, 0);
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
      exp_q.delete();
      cyc_q.delete();
      tick();

      fill_const(20, 20);
      begin_job(10, 32);
      feed(1'b0);
      finish_job();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
